inst_fetch_buffer: RTL and testbench

- Consumer side of the I-cache fetch-group interface: accepts one 4-instruction fetch packet (inst_set_t layout, 4x32 bits) per handshake.
- Unpacks packets into a circular per-instruction queue with a PC tag on each entry.
- Presents up to DEC_WIDTH in-order instructions per cycle to decode.
- Decouples I-cache fetch timing from decode backpressure. Supports pipeline flush on redirect.

---
 rtl/inst_fetch_buffer_if.sv | 28 ++
 rtl/inst_fetch_buffer.sv | 139 +++++++++++++
 tb/tb_inst_fetch_buffer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_buffer_if.sv
// Fetch-packet and decode-lane bundle shared by the fetch buffer and its neighbours.
// slave = buffer side, master = I-cache/decode driving side.
interface inst_fetch_buffer_if #(
  parameter int DEPTH     = 16,
  parameter int DEC_WIDTH = 2
);
  logic                        fq_valid_i;
  logic                        fq_ready_o;
  logic [127:0]                fq_inst_i;
  logic [31:0]                 fq_pc_i;
  logic [1:0]                  fq_start_i;
  logic [DEC_WIDTH-1:0]        dec_valid_o;
  logic [DEC_WIDTH*32-1:0]     dec_inst_o;
  logic [DEC_WIDTH*32-1:0]     dec_pc_o;
  logic                        dec_ready_i;
  logic                        flush_i;
  logic [$clog2(DEPTH):0]      count_o;

  modport slave (
    input  fq_valid_i, fq_inst_i, fq_pc_i, fq_start_i, dec_ready_i, flush_i,
    output fq_ready_o, dec_valid_o, dec_inst_o, dec_pc_o, count_o
  );

  modport master (
    output fq_valid_i, fq_inst_i, fq_pc_i, fq_start_i, dec_ready_i, flush_i,
    input  fq_ready_o, dec_valid_o, dec_inst_o, dec_pc_o, count_o
  );
endinterface

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: unpacks 4-wide fetch packets into a PC-tagged circular queue for decode.
// Latency 1 cycle enqueue-to-decode; accepts a packet only while 4 slots are free, independent of decode.
// FETCH_BUF_PERF_EN adds saturating stall/empty performance counters.
module inst_fetch_buffer #(
  parameter int DEPTH     = 16,
  parameter int DEC_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inst_fetch_buffer_if.slave   fq
`ifdef FETCH_BUF_PERF_EN
  ,
  output logic [31:0]          perf_stall_cnt_o,
  output logic [31:0]          perf_empty_cnt_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   mem_inst_q [DEPTH];
  logic [31:0]   mem_inst_d [DEPTH];
  logic [31:0]   mem_pc_q   [DEPTH];
  logic [31:0]   mem_pc_d   [DEPTH];

  logic                    fq_ready;
  logic [DEC_WIDTH-1:0]    dec_valid;
  logic                    enq;
  logic                    deq;
  logic [2:0]              n_in;
  logic [CW-1:0]           n_out;

  // Readiness looks only at the registered count so decode never gates the fetch handshake.
  always_comb begin
    fq_ready = (cnt_q <= CW'(DEPTH - 4));
    for (int i = 0; i < DEC_WIDTH; i++) begin
      dec_valid[i] = (CW'(i) < cnt_q);
    end
    enq   = fq.fq_valid_i && fq_ready && !fq.flush_i;
    deq   = fq.dec_ready_i && dec_valid[0] && !fq.flush_i;
    n_in  = enq ? (3'd4 - {1'b0, fq.fq_start_i}) : 3'd0;
    n_out = '0;
    if (deq) begin
      n_out = (cnt_q < CW'(DEC_WIDTH)) ? cnt_q : CW'(DEC_WIDTH);
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(n_in);
    rd_ptr_d = rd_ptr_q + AW'(n_out);
    cnt_d    = cnt_q + CW'(n_in) - n_out;
    if (fq.flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  // Slot s lands at wr_ptr + (s - start); the add wraps modulo DEPTH across the array end.
  always_comb begin
    mem_inst_d = mem_inst_q;
    mem_pc_d   = mem_pc_q;
    for (int s = 0; s < 4; s++) begin
      if (enq && (2'(s) >= fq.fq_start_i)) begin
        mem_inst_d[wr_ptr_q + AW'(2'(s) - fq.fq_start_i)] = fq.fq_inst_i[32*s +: 32];
        mem_pc_d[wr_ptr_q + AW'(2'(s) - fq.fq_start_i)]   = {fq.fq_pc_i[31:4], 2'(s), 2'b00};
      end
    end
  end

  always_comb begin
    fq.fq_ready_o  = fq_ready;
    fq.dec_valid_o = dec_valid;
    fq.count_o     = cnt_q;
    fq.dec_inst_o  = '0;
    fq.dec_pc_o    = '0;
    for (int i = 0; i < DEC_WIDTH; i++) begin
      fq.dec_inst_o[32*i +: 32] = mem_inst_q[rd_ptr_q + AW'(i)];
      fq.dec_pc_o[32*i +: 32]   = mem_pc_q[rd_ptr_q + AW'(i)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is payload only; occupancy alone decides what is visible, so it needs no reset.
  always_ff @(posedge clk) begin
    mem_inst_q <= mem_inst_d;
    mem_pc_q   <= mem_pc_d;
  end

`ifdef FETCH_BUF_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] empty_cnt_q, empty_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    empty_cnt_d = empty_cnt_q;
    if (fq.fq_valid_i && !fq_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if ((cnt_q == '0) && !fq.flush_i && (empty_cnt_q != 32'hFFFF_FFFF)) begin
      empty_cnt_d = empty_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      empty_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      empty_cnt_q <= empty_cnt_d;
    end
  end

  assign perf_stall_cnt_o = stall_cnt_q;
  assign perf_empty_cnt_o = empty_cnt_q;
`endif

  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= CW'(DEPTH));
  a_valid_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (fq.fq_valid_i && !fq_ready && !fq.flush_i) |=> fq.fq_valid_i);
  a_thermometer: assert property (@(posedge clk) disable iff (!rst_n)
    ((dec_valid & (dec_valid + DEC_WIDTH'(1))) == '0));

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed vector bench for inst_fetch_buffer (DEPTH=16, DEC_WIDTH=2).
module tb_inst_fetch_buffer;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  inst_fetch_buffer_if #(.DEPTH(16), .DEC_WIDTH(2)) bus ();

`ifdef FETCH_BUF_PERF_EN
  logic [31:0] perf_stall;
  logic [31:0] perf_empty;
`endif

  inst_fetch_buffer #(.DEPTH(16), .DEC_WIDTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fq    (bus)
`ifdef FETCH_BUF_PERF_EN
    ,
    .perf_stall_cnt_o (perf_stall),
    .perf_empty_cnt_o (perf_empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [1:0]   st;
    logic [31:0]  pc;
    logic [127:0] inst;
    logic         rdy;
    logic         fl;
    int           cnt;
    logic         frdy;
    logic [1:0]   dv;
    logic [31:0]  i0, p0, i1, p1;
  } vec_t;

  vec_t        tbl [14];
  logic [31:0] exp_i [$];
  logic [31:0] exp_p [$];

  function automatic logic [127:0] pk(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic vec_t mk(input logic v, input logic [1:0] st, input logic [31:0] pc,
                              input logic [127:0] inst, input logic rdy, input logic fl,
                              input int cnt, input logic frdy, input logic [1:0] dv,
                              input logic [31:0] i0, p0, i1, p1);
    vec_t r;
    r.v = v; r.st = st; r.pc = pc; r.inst = inst; r.rdy = rdy; r.fl = fl;
    r.cnt = cnt; r.frdy = frdy; r.dv = dv; r.i0 = i0; r.p0 = p0; r.i1 = i1; r.p1 = p1;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.fq_valid_i = 1'b0;
    bus.fq_start_i = 2'd0;
    bus.fq_pc_i    = 32'h0;
    bus.fq_inst_i  = '0;
    bus.flush_i    = 1'b0;
  endtask

  // Drives a packet whose slot s carries base+s and records the entries it should produce.
  task automatic send_pkt(input logic [31:0] pc, input logic [1:0] st, input logic [31:0] base);
    bus.fq_valid_i = 1'b1;
    bus.fq_pc_i    = pc;
    bus.fq_start_i = st;
    bus.fq_inst_i  = pk(base, base + 32'd1, base + 32'd2, base + 32'd3);
    for (int s = int'(st); s < 4; s++) begin
      exp_i.push_back(base + 32'(s));
      exp_p.push_back({pc[31:4], 2'(s), 2'b00});
    end
  endtask

  task automatic do_flush();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    exp_i.delete();
    exp_p.delete();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.dec_ready_i = 1'b0;
    idle_in();

    // Reset state and idle after release
    #12;
    chk("rst_count", 32'(bus.count_o), 32'd0);
    chk("rst_ready", 32'(bus.fq_ready_o), 32'd1);
    chk("rst_dvalid", 32'(bus.dec_valid_o), 32'd0);
    rst_n = 1'b1;
    tick();
    bus.dec_ready_i = 1'b1;
    tick();
    chk("idle_dvalid", 32'(bus.dec_valid_o), 32'd0);
    chk("idle_count", 32'(bus.count_o), 32'd0);

    // Table: single packet, partial packet, flush with everything high, simultaneous enq/deq
    tbl[0]  = mk(1, 0, 32'h8000_0010, pk(32'hA0, 32'hA1, 32'hA2, 32'hA3), 1, 0, 4, 1, 2'b11,
                 32'hA0, 32'h8000_0010, 32'hA1, 32'h8000_0014);
    tbl[1]  = mk(0, 0, 32'h0, '0, 1, 0, 2, 1, 2'b11, 32'hA2, 32'h8000_0018, 32'hA3, 32'h8000_001C);
    tbl[2]  = mk(0, 0, 32'h0, '0, 1, 0, 0, 1, 2'b00, 0, 0, 0, 0);
    tbl[3]  = mk(1, 3, 32'h0000_1000, pk(32'h11, 32'h22, 32'h33, 32'hDEAD), 0, 0, 1, 1, 2'b01,
                 32'hDEAD, 32'h0000_100C, 0, 0);
    tbl[4]  = mk(0, 0, 32'h0, '0, 1, 0, 0, 1, 2'b00, 0, 0, 0, 0);
    tbl[5]  = mk(1, 0, 32'h0000_2000, pk(32'hB0, 32'hB1, 32'hB2, 32'hB3), 0, 0, 4, 1, 2'b11,
                 32'hB0, 32'h0000_2000, 32'hB1, 32'h0000_2004);
    tbl[6]  = mk(1, 2, 32'h0000_3000, pk(32'hC0, 32'hC1, 32'hC2, 32'hC3), 0, 0, 6, 1, 2'b11,
                 32'hB0, 32'h0000_2000, 32'hB1, 32'h0000_2004);
    tbl[7]  = mk(1, 0, 32'h0000_4000, pk(32'hD0, 32'hD1, 32'hD2, 32'hD3), 1, 1, 0, 1, 2'b00, 0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 32'h0, '0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0);
    tbl[9]  = mk(1, 0, 32'h0000_5000, pk(32'hE0, 32'hE1, 32'hE2, 32'hE3), 1, 0, 4, 1, 2'b11,
                 32'hE0, 32'h0000_5000, 32'hE1, 32'h0000_5004);
    tbl[10] = mk(1, 1, 32'h0000_6000, pk(32'hF0, 32'hF1, 32'hF2, 32'hF3), 1, 0, 5, 1, 2'b11,
                 32'hE2, 32'h0000_5008, 32'hE3, 32'h0000_500C);
    tbl[11] = mk(0, 0, 32'h0, '0, 1, 0, 3, 1, 2'b11, 32'hF1, 32'h0000_6004, 32'hF2, 32'h0000_6008);
    tbl[12] = mk(0, 0, 32'h0, '0, 1, 0, 1, 1, 2'b01, 32'hF3, 32'h0000_600C, 0, 0);
    tbl[13] = mk(0, 0, 32'h0, '0, 1, 0, 0, 1, 2'b00, 0, 0, 0, 0);

    for (int k = 0; k < 14; k++) begin
      bus.fq_valid_i  = tbl[k].v;
      bus.fq_start_i  = tbl[k].st;
      bus.fq_pc_i     = tbl[k].pc;
      bus.fq_inst_i   = tbl[k].inst;
      bus.dec_ready_i = tbl[k].rdy;
      bus.flush_i     = tbl[k].fl;
      tick();
      chk($sformatf("v%0d_count", k), 32'(bus.count_o), 32'(tbl[k].cnt));
      chk($sformatf("v%0d_ready", k), 32'(bus.fq_ready_o), 32'(tbl[k].frdy));
      chk($sformatf("v%0d_dvalid", k), 32'(bus.dec_valid_o), 32'(tbl[k].dv));
      if (tbl[k].dv[0]) begin
        chk($sformatf("v%0d_inst0", k), bus.dec_inst_o[31:0], tbl[k].i0);
        chk($sformatf("v%0d_pc0", k), bus.dec_pc_o[31:0], tbl[k].p0);
      end
      if (tbl[k].dv[1]) begin
        chk($sformatf("v%0d_inst1", k), bus.dec_inst_o[63:32], tbl[k].i1);
        chk($sformatf("v%0d_pc1", k), bus.dec_pc_o[63:32], tbl[k].p1);
      end
    end
    idle_in();

    // Fill to full under backpressure, then drain FIFO-order across the pointer wrap
    bus.dec_ready_i = 1'b0;
    do_flush();
    for (int p = 0; p < 4; p++) begin
      send_pkt(32'h0001_0000 + 32'(p) * 32'h100, 2'd0, 32'h100 + 32'(p) * 32'h10);
      tick();
      chk($sformatf("fill%0d_count", p), 32'(bus.count_o), 32'(4 * (p + 1)));
      chk($sformatf("fill%0d_ready", p), 32'(bus.fq_ready_o), (p < 3) ? 32'd1 : 32'd0);
    end
    send_pkt(32'h0002_0000, 2'd0, 32'h500);
    tick();
    chk("full_refuse_count", 32'(bus.count_o), 32'd16);
    chk("full_refuse_ready", 32'(bus.fq_ready_o), 32'd0);
    bus.dec_ready_i = 1'b1;
    for (int c = 0; c < 12 && exp_i.size() > 0; c++) begin
      chk($sformatf("drain%0d_inst0", c), bus.dec_inst_o[31:0], exp_i[0]);
      chk($sformatf("drain%0d_pc0", c), bus.dec_pc_o[31:0], exp_p[0]);
      if (exp_i.size() > 1) begin
        chk($sformatf("drain%0d_inst1", c), bus.dec_inst_o[63:32], exp_i[1]);
        chk($sformatf("drain%0d_pc1", c), bus.dec_pc_o[63:32], exp_p[1]);
      end
      tick();
      for (int j = 0; j < 2 && exp_i.size() > 0; j++) begin
        void'(exp_i.pop_front());
        void'(exp_p.pop_front());
      end
      if (c == 0) begin
        chk("drain_cnt14", 32'(bus.count_o), 32'd14);
        chk("drain_ready_low", 32'(bus.fq_ready_o), 32'd0);
      end
      if (c == 1) begin
        chk("drain_cnt12", 32'(bus.count_o), 32'd12);
        chk("drain_ready_back", 32'(bus.fq_ready_o), 32'd1);
      end
      if (c == 2) begin
        chk("drain_enq_deq", 32'(bus.count_o), 32'd14);
        idle_in();
      end
    end
    chk("drain_left", 32'(exp_i.size()), 32'd0);
    chk("drain_empty_count", 32'(bus.count_o), 32'd0);
    chk("drain_empty_dvalid", 32'(bus.dec_valid_o), 32'd0);

    // Park both pointers at 14 with the buffer empty, then split one packet across the end
    bus.dec_ready_i = 1'b0;
    do_flush();
    for (int p = 0; p < 3; p++) begin
      send_pkt(32'h0003_0000, 2'd0, 32'h0);
      tick();
    end
    send_pkt(32'h0003_0000, 2'd3, 32'h0);
    tick();
    idle_in();
    chk("cnt13_count", 32'(bus.count_o), 32'd13);
    chk("cnt13_refuse", 32'(bus.fq_ready_o), 32'd0);
    bus.dec_ready_i = 1'b1;
    tick();
    chk("cnt11_ready", 32'(bus.fq_ready_o), 32'd1);
    bus.dec_ready_i = 1'b0;
    send_pkt(32'h0003_0000, 2'd3, 32'h0);
    tick();
    idle_in();
    bus.dec_ready_i = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    chk("park_count", 32'(bus.count_o), 32'd0);
    bus.dec_ready_i = 1'b0;
    bus.fq_valid_i  = 1'b1;
    bus.fq_start_i  = 2'd0;
    bus.fq_pc_i     = 32'h7770_0020;
    bus.fq_inst_i   = pk(32'h1111_0000, 32'h1111_0001, 32'h1111_0002, 32'h1111_0003);
    tick();
    idle_in();
    chk("wrap_count", 32'(bus.count_o), 32'd4);
    chk("wrap_inst0", bus.dec_inst_o[31:0], 32'h1111_0000);
    chk("wrap_pc0", bus.dec_pc_o[31:0], 32'h7770_0020);
    chk("wrap_inst1", bus.dec_inst_o[63:32], 32'h1111_0001);
    chk("wrap_pc1", bus.dec_pc_o[63:32], 32'h7770_0024);
    bus.dec_ready_i = 1'b1;
    tick();
    chk("wrap_inst2", bus.dec_inst_o[31:0], 32'h1111_0002);
    chk("wrap_pc2", bus.dec_pc_o[31:0], 32'h7770_0028);
    chk("wrap_inst3", bus.dec_inst_o[63:32], 32'h1111_0003);
    chk("wrap_pc3", bus.dec_pc_o[63:32], 32'h7770_002C);
    tick();
    chk("wrap_done_dvalid", 32'(bus.dec_valid_o), 32'd0);

    // Asynchronous reset mid-run with nine entries held
    bus.dec_ready_i = 1'b0;
    do_flush();
    send_pkt(32'h0004_0000, 2'd0, 32'h0);
    tick();
    send_pkt(32'h0004_0000, 2'd0, 32'h0);
    tick();
    send_pkt(32'h0004_0000, 2'd3, 32'h0);
    tick();
    idle_in();
    chk("pre_rst_count", 32'(bus.count_o), 32'd9);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(bus.count_o), 32'd0);
    chk("async_rst_dvalid", 32'(bus.dec_valid_o), 32'd0);
    chk("async_rst_ready", 32'(bus.fq_ready_o), 32'd1);
    #2;
    rst_n = 1'b1;
    bus.dec_ready_i = 1'b1;
    tick();
    chk("post_rst_dvalid", 32'(bus.dec_valid_o), 32'd0);
    tick();
    chk("post_rst_dvalid2", 32'(bus.dec_valid_o), 32'd0);
    chk("post_rst_count", 32'(bus.count_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got no finish expected finish");
    $fatal(1);
  end
endmodule
